fp_round_stage: RTL and testbench

FP_ROUND_STAGE -- requirements
Module: fp_round_stage

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_round.sv | 28 ++
 rtl/fp_round_stage.sv | 90 +++++++++
 tb/tb_fp_round_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point word format for the converter back end: 4-bit significand,
// 3-bit exponent, sign, plus the limits the rounding stage saturates against.
package fp_pkg;

    localparam int SIG_W = 4;
    localparam int EXP_W = 3;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
    localparam logic [SIG_W-1:0] SIG_MAX = 4'b1111;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [SIG_W-1:0] significand;
    } fp_word_t;

endpackage

// File: rtl/fp_round.sv
// Round-half-up on magnitude, renormalising on significand overflow and saturating at max.
// Purely combinational, no latency, no flow control.
import fp_pkg::*;

module fp_round (
    input  fp_word_t i_word,
    input  logic     i_fifth_bit,
    output fp_word_t o_word,
    output logic     o_saturated
);

    always_comb begin
        o_word      = i_word;
        o_saturated = 1'b0;
        if (i_fifth_bit) begin
            if (i_word.significand != SIG_MAX) begin
                o_word.significand = i_word.significand + 1'b1;
            end else if (i_word.exponent != EXP_MAX) begin
                // 1111 + 1 overflows to 10000; keep the leading one and bump the exponent
                o_word.significand = 4'b1000;
                o_word.exponent    = i_word.exponent + 1'b1;
            end else begin
                o_saturated = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_round_stage.sv
// Rounds accepted words into a DEPTH-entry FIFO; 1 cycle to out_valid when empty.
// in_ready drops only when the FIFO is full; head fields hold while out_ready is low.
import fp_pkg::*;

module fp_round_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [SIG_W-1:0] in_significand,
    input  logic [EXP_W-1:0] in_exponent,
    input  logic             in_fifth_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [SIG_W-1:0] out_significand,
    output logic [EXP_W-1:0] out_exponent,
    output logic [CNT_W-1:0] sat_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fp_word_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_sat_count;

    fp_word_t w_in_word;
    fp_word_t w_rounded;
    fp_word_t w_head;
    logic     w_saturated;
    logic     w_push;
    logic     w_pop;

    assign w_in_word = {in_sign, in_exponent, in_significand};

    fp_round u_round (
        .i_word      (w_in_word),
        .i_fifth_bit (in_fifth_bit),
        .o_word      (w_rounded),
        .o_saturated (w_saturated)
    );

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_head          = r_mem[r_rd_ptr];
    assign out_sign        = w_head.sign;
    assign out_significand = w_head.significand;
    assign out_exponent    = w_head.exponent;
    assign sat_count       = r_sat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_rounded;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Counter sticks at all-ones so a long run of overflows never reads as few
            if (w_push && w_saturated && (r_sat_count != {CNT_W{1'b1}})) begin
                r_sat_count <= r_sat_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_stage.sv
// Scoreboarded random and directed bench for fp_round_stage against an arithmetic rounding model.
import fp_pkg::*;

module tb_fp_round_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [3:0] in_significand;
    logic [2:0] in_exponent;
    logic       in_fifth_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [3:0] out_significand;
    logic [2:0] out_exponent;
    logic [7:0] sat_count;

    fp_round_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sign         (in_sign),
        .in_significand  (in_significand),
        .in_exponent     (in_exponent),
        .in_fifth_bit    (in_fifth_bit),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sign        (out_sign),
        .out_significand (out_significand),
        .out_exponent    (out_exponent),
        .sat_count       (sat_count)
    );

    always #5 clk = ~clk;

    int       total = 0;
    int       bad = 0;
    fp_word_t exp_q[$];
    int       exp_sat = 0;
    bit       rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Magnitude + half ulp, truncate; a carry out of the significand halves it and raises the exponent
    function automatic fp_word_t model(input logic s, input logic [3:0] m, input logic [2:0] e,
                                       input logic f, output bit sat);
        int sig;
        int ex;
        fp_word_t w;
        sig = int'(m) + int'(f);
        ex  = int'(e);
        sat = 1'b0;
        if (sig > 15) begin
            sig = sig / 2;
            ex  = ex + 1;
        end
        if (ex > 7) begin
            sig = 15;
            ex  = 7;
            sat = 1'b1;
        end
        w.sign        = s;
        w.exponent    = 3'(ex);
        w.significand = 4'(sig);
        return w;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the word
    task automatic send(input logic s, input logic [3:0] m, input logic [2:0] e,
                        input logic f, output int waited);
        fp_word_t w;
        bit sat;
        bit done;
        done = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_sign = s;
        in_significand = m;
        in_exponent = e;
        in_fifth_bit = f;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                w = model(s, m, e, f, sat);
                exp_q.push_back(w);
                if (sat && exp_sat < 255) exp_sat++;
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_sat = 0;
    endtask

    // Monitor: pops on every output handshake and checks the head holds while stalled
    fp_word_t held;
    bit       held_v = 1'b0;
    fp_word_t cur;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            cur = {out_sign, out_exponent, out_significand};
            if (held_v && out_valid) check("stall_stable", cur, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%0h required=none", cur);
                end else begin
                    check("out_word", cur, exp_q.pop_front());
                end
                held_v = 1'b0;
            end else if (out_valid) begin
                held = cur;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_significand = '0;
        in_exponent = '0;
        in_fifth_bit = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sat", sat_count, 0);
        check("rst_fields", {out_sign, out_exponent, out_significand}, 0);

        // Basic rounding and one-cycle latency
        out_ready = 1'b1;
        send(1'b0, 4'b1011, 3'd3, 1'b1, w);
        check("lat_valid", out_valid, 1);
        check("lat_sig", out_significand, 4'b1100);
        check("lat_exp", out_exponent, 3'd3);
        send(1'b1, 4'b1111, 3'd4, 1'b1, w);
        send(1'b0, 4'b1111, 3'd7, 1'b1, w);
        check("sat_first", sat_count, 1);
        send(1'b0, 4'b0000, 3'd0, 1'b0, w);
        send(1'b1, 4'b1110, 3'd2, 1'b1, w);
        drain();

        // Backpressure: A,B fill, C held until the consumer resumes
        out_ready = 1'b0;
        send(1'b0, 4'b0001, 3'd1, 1'b0, w);
        send(1'b1, 4'b0010, 3'd2, 1'b1, w);
        check("full_in_ready", in_ready, 0);
        fork
            send(1'b0, 4'b0111, 3'd5, 1'b1, w);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("hold_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming: every word accepted without waiting
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), w);
            check("stream_wait", w, 0);
            check("stream_ready", in_ready, 1);
        end
        drain();

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), w);
        end
        drain();
        check("rand_sat", sat_count, exp_sat[7:0]);

        // Reset with queued words discards them
        out_ready = 1'b0;
        send(1'b0, 4'b0101, 3'd1, 1'b1, w);
        send(1'b1, 4'b1001, 3'd6, 1'b0, w);
        do_reset();
        check("rst2_out_valid", out_valid, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_sat", sat_count, 0);
        check("rst2_fields", {out_sign, out_exponent, out_significand}, 0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst2_no_ghost", out_valid, 0);

        // Saturation counter sticks at all-ones
        for (int i = 0; i < 255; i++) begin
            send(1'($urandom), 4'b1111, 3'd7, 1'b1, w);
        end
        check("sat_255", sat_count, exp_sat[7:0]);
        send(1'b0, 4'b1111, 3'd7, 1'b1, w);
        check("sat_hold", sat_count, 255);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
